// File: rtl/ofm_packer_pkg.sv
// Shared accelerator parameters: slice/word widths and block geometry used by
// the output packer and the input parser.
package ofm_packer_pkg;

    localparam int OFM_INPUT_WIDTH  = 80;
    localparam int OFM_OUTPUT_WIDTH = 512;
    localparam int OFM_REG_NUM      = 5;
    localparam int OFM_COMMON_DEN   = OFM_OUTPUT_WIDTH * OFM_REG_NUM;
    localparam int OFM_MAX_CNT      = OFM_COMMON_DEN / OFM_INPUT_WIDTH;

    // Counter width that still works for a single-entry range.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ofm_drain_buf.sv
// Drain side of the packer: holds one packed block and streams it out word by
// word, tracking the last-block tag and the end-of-job done pulse.
module ofm_drain_buf
    import ofm_packer_pkg::*;
#(
    parameter int OUTPUT_WIDTH = OFM_OUTPUT_WIDTH,
    parameter int REG_NUM      = OFM_REG_NUM
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            load,
    input  logic [OUTPUT_WIDTH*REG_NUM-1:0] load_data,
    input  logic                            load_last,
    input  logic                            tag_last,
    input  logic                            empty_done,
    input  logic                            dout_ready,
    output logic [OUTPUT_WIDTH-1:0]         dout,
    output logic                            busy,
    output logic                            dout_last,
    output logic                            done,
    output logic                            last_hs,
    output logic                            done_next
);

    localparam int WC_W = cnt_width(REG_NUM);
    localparam logic [WC_W-1:0] WORD_LAST = WC_W'(REG_NUM - 1);

    logic [OUTPUT_WIDTH*REG_NUM-1:0] drain_reg;
    logic [WC_W-1:0]                 word_cnt;
    logic                            drain_last;
    logic                            hs;

    // valid/ready: a word moves only on an edge where busy & dout_ready;
    // otherwise dout and busy hold unchanged.
    assign hs        = busy & dout_ready;
    assign last_hs   = hs & (word_cnt == WORD_LAST);
    assign done_next = (last_hs & (drain_last | tag_last)) | empty_done;
    assign dout      = drain_reg[OUTPUT_WIDTH*word_cnt +: OUTPUT_WIDTH];
    assign dout_last = busy & drain_last & (word_cnt == WORD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_reg  <= '0;
            word_cnt   <= '0;
            busy       <= 1'b0;
            drain_last <= 1'b0;
            done       <= 1'b0;
        end else if (clear) begin
            drain_reg  <= '0;
            word_cnt   <= '0;
            busy       <= 1'b0;
            drain_last <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= done_next;
            if (load) begin
                drain_reg  <= load_data;
                word_cnt   <= '0;
                busy       <= 1'b1;
                drain_last <= load_last;
            end else if (last_hs) begin
                drain_reg  <= '0;
                word_cnt   <= '0;
                busy       <= 1'b0;
                drain_last <= 1'b0;
            end else begin
                if (hs)
                    word_cnt <= word_cnt + 1'b1;
                if (tag_last)
                    drain_last <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ofm_packer.sv
// Packs conv-array result slices into fixed-size blocks of AXIS words, with a
// fill buffer in front of a drain buffer so filling overlaps draining.
module ofm_packer
    import ofm_packer_pkg::*;
#(
    parameter int INPUT_WIDTH  = OFM_INPUT_WIDTH,
    parameter int OUTPUT_WIDTH = OFM_OUTPUT_WIDTH,
    parameter int REG_NUM      = OFM_REG_NUM
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_conv_pulse,
    input  logic [INPUT_WIDTH-1:0]  din,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic [OUTPUT_WIDTH-1:0] dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    dout_last,
    input  logic                    end_conv,
    output logic                    done
);

    localparam int COMMON_DEN = OUTPUT_WIDTH * REG_NUM;
    localparam int MAX_CNT    = COMMON_DEN / INPUT_WIDTH;
    localparam int CNT_W      = cnt_width(MAX_CNT);
    localparam logic [CNT_W-1:0] FM_LAST = CNT_W'(MAX_CNT - 1);

    logic [COMMON_DEN-1:0] fill_reg;
    logic [CNT_W-1:0]      fm_cnt;
    logic                  full_pending;
    logic                  fill_last;
    logic                  flush_pending;

    logic accept;
    logic transfer;
    logic buffered;
    logic drain_busy;
    logic last_hs;
    logic done_next;
    logic empty_done;
    logic tag_drain_last;

    assign din_ready  = !full_pending & !flush_pending;
    assign accept     = din_valid & din_ready;
    assign transfer   = full_pending & (!drain_busy | last_hs);
    assign dout_valid = drain_busy;

    // A slice arriving with end_conv counts as buffered data for the flush.
    assign buffered       = (fm_cnt != '0) | accept | full_pending;
    assign empty_done     = end_conv & !buffered & !drain_busy;
    assign tag_drain_last = end_conv & !buffered & drain_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_reg      <= '0;
            fm_cnt        <= '0;
            full_pending  <= 1'b0;
            fill_last     <= 1'b0;
            flush_pending <= 1'b0;
        end else if (start_conv_pulse) begin
            fill_reg      <= '0;
            fm_cnt        <= '0;
            full_pending  <= 1'b0;
            fill_last     <= 1'b0;
            flush_pending <= 1'b0;
        end else begin
            // full_pending blocks accepts, so transfer and accept never coincide.
            if (transfer) begin
                fill_reg     <= '0;
                fm_cnt       <= '0;
                full_pending <= 1'b0;
                fill_last    <= 1'b0;
            end else begin
                if (accept) begin
                    fill_reg[INPUT_WIDTH*fm_cnt +: INPUT_WIDTH] <= din;
                    fm_cnt <= (fm_cnt == FM_LAST) ? '0 : fm_cnt + 1'b1;
                    if (fm_cnt == FM_LAST)
                        full_pending <= 1'b1;
                end
                if (end_conv & buffered) begin
                    full_pending <= 1'b1;
                    fill_last    <= 1'b1;
                end
            end

            if (done_next)
                flush_pending <= 1'b0;
            else if (end_conv)
                flush_pending <= 1'b1;
        end
    end

    ofm_drain_buf #(
        .OUTPUT_WIDTH (OUTPUT_WIDTH),
        .REG_NUM      (REG_NUM)
    ) u_drain (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_conv_pulse),
        .load       (transfer),
        .load_data  (fill_reg),
        .load_last  (fill_last | end_conv),
        .tag_last   (tag_drain_last),
        .empty_done (empty_done),
        .dout_ready (dout_ready),
        .dout       (dout),
        .busy       (drain_busy),
        .dout_last  (dout_last),
        .done       (done),
        .last_hs    (last_hs),
        .done_next  (done_next)
    );

endmodule

// File: tb/tb_ofm_packer.sv
// Directed bench for ofm_packer: block packing, back-to-back blocks, stalls,
// partial flush, empty flush, drain-time flush, reset and start abort.
`timescale 1ns/1ps
module tb_ofm_packer;

    localparam int IW = 80;
    localparam int OW = 512;
    localparam int RN = 5;
    localparam int CD = OW * RN;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_conv_pulse;
    logic [IW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic [OW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_last;
    logic          end_conv;
    logic          done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ofm_packer dut (
        .clk              (clk),
        .rst              (rst),
        .start_conv_pulse (start_conv_pulse),
        .din              (din),
        .din_valid        (din_valid),
        .din_ready        (din_ready),
        .dout             (dout),
        .dout_valid       (dout_valid),
        .dout_ready       (dout_ready),
        .dout_last        (dout_last),
        .end_conv         (end_conv),
        .done             (done)
    );

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] slice_val(input int blk, input int k);
        return {8'(blk + 1), 64'(k * 37 + blk * 1000 + 5), 8'(k)};
    endfunction

    function automatic logic [CD-1:0] block_model(input int blk, input int from, input int n);
        logic [CD-1:0] m = '0;
        for (int j = 0; j < n; j++)
            m[IW*j +: IW] = slice_val(blk, from + j);
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_slice(input logic [IW-1:0] v, output int waits);
        int w = 0;
        din       = v;
        din_valid = 1'b1;
        while (!din_ready && w < 200) begin
            tick();
            w++;
        end
        if (!din_ready)
            chk("din_ready_timeout", OW'(din_ready), OW'(1));
        tick();
        din_valid = 1'b0;
        waits     = w;
    endtask

    task automatic send_block(input int blk, input int from, input int n, output int waits_total);
        int w;
        waits_total = 0;
        for (int k = from; k < from + n; k++) begin
            send_slice(slice_val(blk, k), w);
            waits_total += w;
        end
    endtask

    task automatic expect_block(input string tag, input logic [CD-1:0] m, input logic last_exp);
        int w = 0;
        while (!dout_valid && w < 100) begin
            tick();
            w++;
        end
        chk({tag, "_valid"}, OW'(dout_valid), OW'(1));
        for (int i = 0; i < RN; i++) begin
            chk($sformatf("%s_w%0d", tag, i), dout, m[OW*i +: OW]);
            chk($sformatf("%s_last%0d", tag, i), OW'(dout_last), OW'(last_exp && i == RN - 1));
            tick();
            end_conv = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dout"}, dout, '0);
        chk({tag, "_dout_valid"}, OW'(dout_valid), OW'(0));
        chk({tag, "_dout_last"}, OW'(dout_last), OW'(0));
        chk({tag, "_done"}, OW'(done), OW'(0));
        chk({tag, "_din_ready"}, OW'(din_ready), OW'(1));
    endtask

    initial begin
        logic [OW-1:0] w0;
        logic [CD-1:0] m;
        int            w;
        int            wb;
        int            stable;
        int            seen_valid;

        rst              = 1'b1;
        start_conv_pulse = 1'b0;
        din              = '0;
        din_valid        = 1'b0;
        dout_ready       = 1'b1;
        end_conv         = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst = 1'b0;
        tick();
        start_conv_pulse = 1'b1;
        tick();
        start_conv_pulse = 1'b0;

        // A: one full block, latency and lane placement
        send_block(0, 0, 31, w);
        send_slice(slice_val(0, 31), w);
        chk("a_full_din_ready", OW'(din_ready), OW'(0));
        chk("a_valid_before_xfer", OW'(dout_valid), OW'(0));
        tick();
        chk("a_valid_after_xfer", OW'(dout_valid), OW'(1));
        chk("a_din_ready_after_xfer", OW'(din_ready), OW'(1));
        w0 = dout;
        chk("a_w0_byte0", OW'(w0[7:0]), OW'(8'h00));
        chk("a_w0_byte80", OW'(w0[87:80]), OW'(8'h01));
        expect_block("a", block_model(0, 0, 32), 1'b0);
        chk("a_idle_valid", OW'(dout_valid), OW'(0));
        chk("a_no_done", OW'(done), OW'(0));

        // B: 64 slices back to back
        fork
            begin
                send_block(1, 0, 64, wb);
                chk("b_end_din_ready_low", OW'(din_ready), OW'(0));
                tick();
                chk("b_end_din_ready_back", OW'(din_ready), OW'(1));
                chk("b_waits", OW'(wb), OW'(1));
            end
            begin
                expect_block("b0", block_model(1, 0, 32), 1'b0);
                expect_block("b1", block_model(1, 32, 32), 1'b0);
            end
        join
        chk("b_no_done", OW'(done), OW'(0));

        // C: downstream stall while a second block fills
        m = block_model(2, 0, 32);
        send_block(2, 0, 32, w);
        tick();
        chk("c_w0", dout, m[0 +: OW]);
        tick();
        chk("c_w1", dout, m[OW +: OW]);
        tick();
        dout_ready = 1'b0;
        stable     = 0;
        for (int k = 0; k < 32; k++) begin
            send_slice(slice_val(3, k), w);
            if (dout === m[2*OW +: OW] && dout_valid === 1'b1)
                stable++;
        end
        chk("c_stable_fill", OW'(stable), OW'(32));
        chk("c_pending_din_ready", OW'(din_ready), OW'(0));
        stable = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (dout === m[2*OW +: OW] && dout_valid === 1'b1 && din_ready === 1'b0)
                stable++;
        end
        chk("c_stable_stall", OW'(stable), OW'(20));
        dout_ready = 1'b1;
        chk("c_w2", dout, m[2*OW +: OW]);
        tick();
        chk("c_w3", dout, m[3*OW +: OW]);
        tick();
        chk("c_w4", dout, m[4*OW +: OW]);
        tick();
        chk("c_no_bubble", OW'(dout_valid), OW'(1));
        chk("c_din_ready_after", OW'(din_ready), OW'(1));
        expect_block("c3", block_model(3, 0, 32), 1'b0);

        // D: partial block flushed by end_conv
        send_block(4, 0, 7, w);
        end_conv = 1'b1;
        tick();
        end_conv = 1'b0;
        chk("d_flush_din_ready", OW'(din_ready), OW'(0));
        chk("d_valid_before_xfer", OW'(dout_valid), OW'(0));
        expect_block("d", block_model(4, 0, 7), 1'b1);
        chk("d_done", OW'(done), OW'(1));
        chk("d_idle_valid", OW'(dout_valid), OW'(0));
        chk("d_din_ready_after", OW'(din_ready), OW'(1));
        tick();
        chk("d_done_pulse", OW'(done), OW'(0));

        // E: end_conv with nothing buffered
        end_conv = 1'b1;
        tick();
        end_conv = 1'b0;
        chk("e_done", OW'(done), OW'(1));
        chk("e_din_ready", OW'(din_ready), OW'(1));
        seen_valid = (dout_valid === 1'b1) ? 1 : 0;
        tick();
        chk("e_done_pulse", OW'(done), OW'(0));
        for (int k = 0; k < 5; k++) begin
            if (dout_valid !== 1'b0)
                seen_valid++;
            tick();
        end
        chk("e_never_valid", OW'(seen_valid), OW'(0));

        // G: end_conv while a block is draining and nothing is filling
        send_block(5, 0, 32, w);
        tick();
        end_conv = 1'b1;
        expect_block("g", block_model(5, 0, 32), 1'b1);
        chk("g_done", OW'(done), OW'(1));
        tick();
        chk("g_done_pulse", OW'(done), OW'(0));

        // F: async reset mid-drain, start abort mid-fill, then a fresh block
        send_block(6, 0, 32, w);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk_reset_outputs("f_rst");
        tick();
        rst = 1'b0;
        tick();
        send_block(7, 0, 10, w);
        start_conv_pulse = 1'b1;
        tick();
        start_conv_pulse = 1'b0;
        chk_reset_outputs("f_start");
        send_block(8, 0, 32, w);
        expect_block("f", block_model(8, 0, 32), 1'b0);
        chk("f_no_done", OW'(done), OW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ofm_packer.md
OFM_PACKER -- requirements
Module: ofm_packer

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 80, width of one output-feature-map slice from the conv array.
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 512, width of one outbound AXIS data word.
REQ-003 SHALL have parameter REG_NUM, default 5, number of output words per packed block.
REQ-004 SHALL have derived parameters COMMON_DEN = OUTPUT_WIDTH*REG_NUM (2560) and MAX_CNT = COMMON_DEN/INPUT_WIDTH (32 slices per block).
REQ-005 clk  in  1  sole clock; all logic on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start_conv_pulse  in  1  one-cycle pulse at the start of a conv job.
REQ-008 din  in  INPUT_WIDTH  result slice.
REQ-009 din_valid  in  1  din is valid.
REQ-010 din_ready  out  1  packer accepts din this cycle.
REQ-011 dout  out  OUTPUT_WIDTH  packed word to the AXIS master.
REQ-012 dout_valid  out  1  dout is valid.
REQ-013 dout_ready  in  1  downstream accepts dout.
REQ-014 dout_last  out  1  final word of the job (TLAST).
REQ-015 end_conv  in  1  one-cycle pulse; no more slices follow.
REQ-016 done  out  1  one-cycle pulse after the job is fully drained.

Function
REQ-017 Slice accept = din_valid & din_ready; word handshake = dout_valid & dout_ready.
REQ-018 Fill register (COMMON_DEN bits) and fill counter fm_cnt (0..MAX_CNT-1): accepted slice k of a block is written to bits [INPUT_WIDTH*k +: INPUT_WIDTH], and fm_cnt increments, wrapping to 0 after MAX_CNT-1.
REQ-019 The MAX_CNT-th accept sets full_pending; din_ready = !full_pending & !flush_pending.
REQ-020 Transfer occurs on the edge where full_pending & (drain idle | handshake of drain word REG_NUM-1). The fill register is copied to the drain register, the fill register is cleared to zero, and full_pending is cleared.
REQ-021 Drain register: word_cnt (0..REG_NUM-1). dout = drain bits [OUTPUT_WIDTH*word_cnt +: OUTPUT_WIDTH]; dout_valid = drain_busy.
REQ-022 word_cnt advances only on handshake; dout and dout_valid SHALL hold while dout_valid & !dout_ready.
REQ-023 Latency: the MAX_CNT-th slice is accepted at edge N with the drain idle; transfer occurs at edge N+1; dout_valid is high from edge N+1, with word 0.
REQ-024 A back-to-back block arriving while the drain is busy transfers on the handshake of the last drain word, with no dout_valid bubble.
REQ-025 end_conv with fm_cnt>0 and !full_pending SHALL set full_pending and tag the block last; unfilled slices remain zero.
REQ-026 end_conv with full_pending set SHALL tag the pending block last.
REQ-027 end_conv with fm_cnt==0, !full_pending and the drain busy SHALL tag the current drain block last.
REQ-028 end_conv with nothing buffered SHALL pulse done on the next edge and emit no word.
REQ-029 A slice accepted in the same cycle as end_conv belongs to the flushed block.
REQ-030 flush_pending is set by end_conv and cleared with done; din_ready is low meanwhile.
REQ-031 dout_last is high only with dout_valid on word REG_NUM-1 of the last-tagged block.
REQ-032 done pulses on the edge after the handshake of that word.
REQ-033 start_conv_pulse (synchronous) SHALL clear counters, flags, fill and drain registers and dout_valid, aborting any job, and takes priority over all other events.

Reset
REQ-034 While rst is high, the block SHALL hold: dout=0, dout_valid=0, dout_last=0, done=0, din_ready=1, fm_cnt=0, word_cnt=0, all flags 0, all registers 0.

Structure
REQ-035 Width defaults and MAX_CNT SHALL reside in the shared accelerator parameter package, also used by ifm_parser.
REQ-036 One sub-module, ofm_drain_buf (drain register, word_cnt, valid/last/done logic), SHALL be instantiated; the fill logic stays in the top level.

Verification
REQ-037 Feed 32 slices with din[7:0]=k and dout_ready=1: 5 words appear starting the cycle after transfer, word0[7:0]=0, word0[87:80]=1, and dout_last=0.
REQ-038 Feed 64 slices back-to-back with dout_ready=1: 10 contiguous words, din_ready low exactly 1 cycle per block.
REQ-039 Hold dout_ready=0 for 20 cycles mid-block: dout remains stable, the second block stalls with full_pending and din_ready=0, and no data is lost.
REQ-040 Feed 7 slices then end_conv: 5 words appear, slices 7..31 are zero, dout_last is on word 4, and done pulses 1 cycle after its handshake.
REQ-041 end_conv with no data: done on the next cycle and dout_valid never asserts.
REQ-042 Assert rst mid-drain, then start_conv_pulse mid-fill: outputs return to REQ-034 values and a fresh block then packs correctly.
